// File: rtl/aes_core_arbiter.sv
// Rotating-priority arbiter sharing one AES block core among NUM_REQ requesters,
// with a watchdog that aborts a transaction whose core never reports done.
module aes_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*128-1:0]   req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [127:0]             rsp_data,
  output logic                     err,
  output logic [ID_W-1:0]          err_id,
  output logic                     busy,
  output logic                     aes_start,
  output logic [127:0]             aes_in,
  input  logic [127:0]             aes_out,
  input  logic                     aes_done,
  input  logic                     aes_busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [ID_W-1:0]     owner, owner_nxt, owner_adv;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       scan;
  logic                found;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt, rsp_valid_nxt;
  logic [127:0]        rsp_data_nxt, aes_in_nxt, win_data;
  logic                err_nxt, aes_start_nxt;
  logic [ID_W-1:0]     err_id_nxt;
  logic                grant_ok, timeout_hit;

  // First asserted request at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ))
        scan = scan - (ID_W+1)'(NUM_REQ);
      if (!found && req[scan[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[ID_W-1:0];
      end
    end
    win_data = req_data[128*winner +: 128];
  end

  assign grant_ok    = found && !aes_busy;
  assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign owner_adv   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (aes_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; done takes precedence over the watchdog.
  always_comb begin
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    err_nxt       = 1'b0;
    aes_start_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    aes_in_nxt    = aes_in;
    err_id_nxt    = err_id;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    timer_nxt     = timer;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          gnt_nxt[winner] = 1'b1;
          owner_nxt       = winner;
          aes_in_nxt      = win_data;
        end
      end
      ISSUE: begin
        aes_start_nxt = 1'b1;
        timer_nxt     = '0;
      end
      WAIT: begin
        if (aes_done) begin
          rsp_data_nxt         = aes_out;
          rsp_valid_nxt[owner] = 1'b1;
          ptr_nxt              = owner_adv;
        end else if (timeout_hit) begin
          err_nxt    = 1'b1;
          err_id_nxt = owner;
          ptr_nxt    = owner_adv;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      err_id    <= '0;
      busy      <= 1'b0;
      aes_start <= 1'b0;
      aes_in    <= '0;
      ptr       <= '0;
      owner     <= '0;
      timer     <= '0;
    end else begin
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      err       <= err_nxt;
      err_id    <= err_id_nxt;
      busy      <= (state_nxt != IDLE);
      aes_start <= aes_start_nxt;
      aes_in    <= aes_in_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      timer     <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboarded bench for aes_core_arbiter: a transaction-level rotating-priority model
// predicts grant order and results; a negedge monitor checks what the DUT presents.
module tb_aes_core_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ID_W           = 2;
  localparam int TIMEOUT_CYCLES = 64;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*128-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]      gnt, rsp_valid;
  logic [127:0]            rsp_data, aes_in;
  logic                    err, busy, aes_start;
  logic [ID_W-1:0]         err_id;
  logic [127:0]            aes_out = '0;
  logic                    aes_done = 1'b0;
  logic                    aes_busy;

  aes_core_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .err_id(err_id),
    .busy(busy), .aes_start(aes_start), .aes_in(aes_in), .aes_out(aes_out),
    .aes_done(aes_done), .aes_busy(aes_busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int           gnt_q[$];
  int           rsp_id_q[$];
  logic [127:0] rsp_dat_q[$];
  int           err_q[$];

  int           m_ptr = 0;
  logic [127:0] data_tab [NUM_REQ][4];
  int           cnt [NUM_REQ];
  int           pos [NUM_REQ];
  bit           active = 1'b0;

  bit   hang = 1'b0;
  bit   busy_force = 1'b0;
  int   lat_force = 0;
  logic core_busy = 1'b0;
  int   stub_cnt = 0;
  logic [127:0] stub_in = '0;
  int   cyc = 0;

  // Stand-in for the cipher: a keyed permutation whose image of zero is the known zero-key vector.
  function automatic logic [127:0] cipher(input logic [127:0] x);
    return {x[63:0], x[127:64]} ^ ZERO_CT;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  assign aes_busy = core_busy | busy_force;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: not reset by rst, so a late done can arrive after an arbiter reset.
  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (aes_start === 1'b1 && !core_busy) begin
      if (!hang) begin
        core_busy <= 1'b1;
        stub_cnt  <= (lat_force > 0) ? lat_force : int'($urandom_range(1, 8));
        stub_in   <= aes_in;
      end
    end else if (core_busy) begin
      if (stub_cnt <= 1) begin
        aes_done  <= 1'b1;
        aes_out   <= cipher(stub_in);
        core_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  int   mon_e;
  int   start_cyc = 0;
  logic mon_prev_gnt = 1'b0;
  logic mon_prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        checkOutput("gnt_pending", 128'(gnt_q.size() > 0), 128'(1));
        if (gnt_q.size() > 0) begin
          mon_e = gnt_q.pop_front();
          checkOutput("gnt_owner", 128'(gnt), 128'(onehot(mon_e)));
        end
      end
      if (aes_start) begin
        checkOutput("start_after_gnt", 128'(mon_prev_gnt), 128'(1));
        checkOutput("busy_with_start", 128'(busy), 128'(1));
        start_cyc = cyc;
      end
      if (rsp_valid != '0) begin
        checkOutput("rsp_after_done", 128'(mon_prev_done), 128'(1));
        checkOutput("rsp_pending", 128'(rsp_id_q.size() > 0), 128'(1));
        if (rsp_id_q.size() > 0) begin
          mon_e = rsp_id_q.pop_front();
          checkOutput("rsp_valid_owner", 128'(rsp_valid), 128'(onehot(mon_e)));
          checkOutput("rsp_data", rsp_data, rsp_dat_q.pop_front());
        end
      end
      if (err) begin
        checkOutput("err_pending", 128'(err_q.size() > 0), 128'(1));
        if (err_q.size() > 0) begin
          mon_e = err_q.pop_front();
          checkOutput("err_id", 128'(err_id), 128'(mon_e));
          checkOutput("err_timing", 128'(cyc - start_cyc), 128'(TIMEOUT_CYCLES));
        end
      end
    end
    mon_prev_gnt  = (gnt != '0);
    mon_prev_done = aes_done;
  end

  // Requesters: drop on grant, re-raise with the next block after their own result or abort.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) req[i] = 1'b0;
      if (active && (rsp_valid[i] || (err && err_id == ID_W'(i)))) begin
        pos[i]++;
        if (pos[i] < cnt[i]) begin
          req[i] = 1'b1;
          req_data[i*128 +: 128] = data_tab[i][pos[i]];
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int reps,
                               input bit zero_data, input bit hang_mode);
    int left [NUM_REQ];
    int total;
    int w;
    int idx;
    hang  = hang_mode;
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i]  = mask[i] ? ((reps > 0) ? reps : int'($urandom_range(1, 3))) : 0;
      pos[i]  = 0;
      left[i] = cnt[i];
      total  += cnt[i];
      for (int k = 0; k < 4; k++)
        data_tab[i][k] = zero_data ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
    end
    // Each transaction serves the first still-wanting requester from the rotating pointer.
    for (int t = 0; t < total; t++) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (w < 0 && left[idx] > 0) w = idx;
      end
      gnt_q.push_back(w);
      if (hang_mode) err_q.push_back(w);
      else begin
        rsp_id_q.push_back(w);
        rsp_dat_q.push_back(cipher(data_tab[w][cnt[w] - left[w]]));
      end
      left[w]--;
      m_ptr = (w + 1) % NUM_REQ;
    end
    active = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      if (mask[i]) begin
        req[i] = 1'b1;
        req_data[i*128 +: 128] = data_tab[i][0];
      end
  endtask

  task automatic drainBatch();
    int guard;
    bit fin;
    guard = 0;
    fin   = 1'b0;
    while (!fin && guard < 2000) begin
      tick();
      guard++;
      fin = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (pos[i] < cnt[i]) fin = 1'b0;
    end
    checkOutput("drain_complete", 128'(fin), 128'(1));
    active = 1'b0;
    req    = '0;
    hang   = 1'b0;
    repeat (3) tick();
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gnt", 128'(gnt), 128'(0));
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    checkOutput("rst_rsp_data", rsp_data, 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    checkOutput("rst_err_id", 128'(err_id), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_aes_start", 128'(aes_start), 128'(0));
    checkOutput("rst_aes_in", aes_in, 128'(0));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    req = '0;
    req_data = '0;
    m_ptr = 0;
    repeat (2) tick();
    checkResetValues();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    bit seen;
    bit done_seen;
    int rsp_cnt;
    int gcount;

    $display("[TB] reset and single zero-block request");
    resetDut();
    applyStimulus(4'b0001, 1, 1'b1, 1'b0);
    tick();
    checkOutput("t1_gnt_plus1", 128'(gnt), 128'(4'b0001));
    tick();
    checkOutput("t1_start_plus2", 128'(aes_start), 128'(1));
    drainBatch();
    checkOutput("t1_rsp_data", rsp_data, ZERO_CT);

    $display("[TB] all four requesters from ptr=0");
    resetDut();
    applyStimulus(4'b1111, 1, 1'b0, 1'b0);
    drainBatch();

    $display("[TB] requesters 1 and 3 held with ptr=2");
    applyStimulus(4'b0010, 1, 1'b0, 1'b0);
    drainBatch();
    applyStimulus(4'b1010, 2, 1'b0, 1'b0);
    drainBatch();

    $display("[TB] randomized batches");
    for (int n = 0; n < 16; n++) begin
      applyStimulus(NUM_REQ'($urandom_range(1, 15)), 0, 1'b0, 1'b0);
      drainBatch();
    end

    $display("[TB] core never completes");
    applyStimulus(4'b0101, 1, 1'b0, 1'b1);
    drainBatch();
    applyStimulus(4'b0110, 1, 1'b0, 1'b0);
    drainBatch();

    $display("[TB] reset during WAIT with late done");
    lat_force = 8;
    gnt_q.push_back(0);
    req[0] = 1'b1;
    req_data[127:0] = {$urandom, $urandom, $urandom, $urandom};
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (aes_start) seen = 1'b1;
    end
    checkOutput("t5_start_seen", 128'(seen), 128'(1));
    repeat (3) tick();
    rst = 1'b1;
    req = '0;
    tick();
    checkResetValues();
    rst = 1'b0;
    m_ptr = 0;
    done_seen = 1'b0;
    rsp_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (aes_done) done_seen = 1'b1;
      if (rsp_valid != '0) rsp_cnt++;
    end
    checkOutput("t5_late_done_fired", 128'(done_seen), 128'(1));
    checkOutput("t5_no_rsp", 128'(rsp_cnt), 128'(0));
    checkOutput("t5_idle_after", 128'(busy), 128'(0));
    checkOutput("t5_rsp_data_clear", rsp_data, 128'(0));
    lat_force = 0;

    $display("[TB] core busy holds off grant");
    busy_force = 1'b1;
    applyStimulus(4'b0010, 1, 1'b0, 1'b0);
    gcount = 0;
    repeat (6) begin
      tick();
      if (gnt != '0) gcount++;
    end
    checkOutput("t6_no_gnt_while_busy", 128'(gcount), 128'(0));
    busy_force = 1'b0;
    tick();
    checkOutput("t6_gnt_after_busy", 128'(gnt), 128'(4'b0010));
    drainBatch();

    checkOutput("gnt_q_empty", 128'(gnt_q.size()), 128'(0));
    checkOutput("rsp_q_empty", 128'(rsp_id_q.size()), 128'(0));
    checkOutput("err_q_empty", 128'(err_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
